spram_stream_writer: RTL and testbench
======================================

# spram_stream_writer

Sequential loader that takes a valid/ready data stream and writes it into a single-port RAM at consecutive addresses, starting from a programmable base, for a programmable word count. It is the write-side counterpart of the sequential ROM/RAM read path: it fills the memory image that a sequential reader later walks address by address. It sits between a stream source (host/DMA/decoder) and the write port of a single-port RAM of identical DATA_WIDTH/DEPTH.

## Interface
Parameters:
- DATA_WIDTH, 8, word width
- DEPTH, 256, number of RAM words (≥2; need not be a power of 2)
- AD_WIDTH, derived, (DEPTH >= 2) ? $clog2(DEPTH) : 1; not overridable

Ports:
- CLK_I  in  1  single clock, rising edge
- NRST_I  in  1  synchronous, active-low reset
- START_I  in  1  start request, sampled in IDLE only
- BASE_I  in  AD_WIDTH  first write address
- LEN_I  in  AD_WIDTH+1  words per pass, 1..DEPTH
- CONT_I  in  1  continuous mode, latched at START
- ABORT_I  in  1  terminate current transfer
- S_DATA_I  in  DATA_WIDTH  stream data
- S_VALID_I  in  1  stream valid
- S_READY_O  out  1  stream ready
- WE_O  out  1  RAM write enable
- WADDR_O  out  AD_WIDTH  RAM write address
- WDATA_O  out  DATA_WIDTH  RAM write data
- BUSY_O  out  1  high in RUN
- DONE_O  out  1  one-cycle pass-complete pulse
- COUNT_O  out  AD_WIDTH+1  words written in current pass
- CHECKSUM_O  out  DATA_WIDTH  see Configuration

## Operation
- FSM states: IDLE, RUN.
- IDLE → RUN: START_I=1, LEN_I in 1..DEPTH, BASE_I < DEPTH. Latch base, len, CONT_I; addr←BASE_I; COUNT_O←0. Otherwise START ignored (no DONE).
- LEN_I > DEPTH: clamped to DEPTH. LEN_I=0: start ignored.
- S_READY_O = (state==RUN) && !ABORT_I; low in IDLE.
- Handshake (S_VALID_I && S_READY_O): next cycle WE_O=1, WADDR_O=addr, WDATA_O=S_DATA_I; addr←(addr==DEPTH-1)?0:addr+1 (wrap modulo DEPTH, not 2^AD_WIDTH); COUNT_O+1.
- No handshake: WE_O=0 next cycle; WADDR_O/WDATA_O hold last value.
- Final handshake of pass (COUNT_O==len-1): COUNT_O←0, DONE_O=1 next cycle (same cycle as final WE_O). CONT=0 → IDLE. CONT=1 → stay RUN, addr←base, next pass begins with no bubble.
- ABORT_I in RUN: no handshake that cycle, → IDLE, no DONE, COUNT_O holds partial count. ABORT_I in IDLE ignored.
- START_I in RUN ignored.
- RUN → IDLE only via final handshake (CONT=0) or ABORT_I.

## Timing
- Reset (NRST_I=0 at clock edge): state IDLE; S_READY_O, WE_O, BUSY_O, DONE_O=0; WADDR_O, WDATA_O, COUNT_O, CHECKSUM_O=0. Reset mid-transfer discards the transfer; no DONE.
- START sampled at edge t → BUSY_O=1, S_READY_O=1 from t+1.
- Latency: handshake at edge t → WE_O/WADDR_O/WDATA_O valid after t, written by RAM at t+1.
- Throughput: one word per cycle while S_VALID_I held high.
- Final handshake at edge t → DONE_O high one cycle after t; BUSY_O/S_READY_O low after t (CONT=0); new START accepted at edge t+1.
- WE_O, WADDR_O, WDATA_O, DONE_O, BUSY_O, COUNT_O registered; S_READY_O combinational from state and ABORT_I only (no path from S_VALID_I).

## Configuration
- SPRAM_STREAM_WRITER_CHECKSUM_EN defined: CHECKSUM_O = XOR of all words accepted since last accepted START; cleared on START; updated with same latency as WE_O; final value valid while DONE_O=1; restarts from 0 each CONT pass.
- Undefined: no checksum logic; CHECKSUM_O tied to 0.

## Structure
- Package spram_stream_writer_pkg: state enum typedef (IDLE, RUN), AD_WIDTH derivation function.
- Sub-module spram_wr_addr_gen: modulo-DEPTH address counter with load (base) and increment; everything else in top.

## Test plan
DATA_WIDTH=8, DEPTH=256 unless stated.
- Reset then START, BASE=0, LEN=256, stream FF,FE..00 with VALID constant → 256 consecutive WE_O cycles, WADDR 00..FF, WDATA FF-addr, DONE_O one cycle with last write, BUSY_O low after.
- BASE=F0, LEN=32 → WADDR F0..FF then 00..0F; DONE after 32 writes; checksum (macro on) equals XOR of sent words.
- DEPTH=200, BASE=C6, LEN=4 → WADDR C6,C7,00,01.
- VALID toggled 1,0,1,0 → WE_O only after valid cycles; COUNT_O increments only on handshake.
- CONT=1, BASE=10, LEN=3, 7 words → WADDR 10,11,12,10,11,12,10; DONE pulses after words 3 and 6; BUSY stays high.
- ABORT_I after 5 of LEN=10 → S_READY_O low that cycle, IDLE next, COUNT_O=5, no DONE; NRST_I low mid-transfer → all outputs 0 next cycle.

Source files
------------

// File: rtl/spram_stream_writer_pkg.sv
// Shared types and helpers for the stream-to-single-port-RAM writer.
// Holds the FSM state encoding and the address-width derivation.
package spram_stream_writer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Address width for a RAM of 'depth' words; a 1-word RAM still needs one bit.
    function automatic int calc_ad_width(input int depth);
        return (depth >= 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/spram_wr_addr_gen.sv
// Write-address counter that wraps modulo DEPTH (not modulo 2^AD_WIDTH),
// with a synchronous load of the base address taking priority over increment.
module spram_wr_addr_gen #(
    parameter int DEPTH    = 256,
    parameter int AD_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [AD_WIDTH-1:0] base,
    input  logic                inc,
    output logic [AD_WIDTH-1:0] addr
);

    localparam logic [AD_WIDTH-1:0] LAST_ADDR = AD_WIDTH'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= base;
        end else if (inc) begin
            addr <= (addr == LAST_ADDR) ? '0 : addr + AD_WIDTH'(1);
        end
    end

endmodule

// File: rtl/spram_stream_writer.sv
// Loads a valid/ready stream into a single-port RAM at consecutive addresses.
// Optional running XOR checksum enabled by SPRAM_STREAM_WRITER_CHECKSUM_EN.
module spram_stream_writer
    import spram_stream_writer_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 256,
    localparam int AD_WIDTH   = calc_ad_width(DEPTH)
) (
    input  logic                  CLK_I,
    input  logic                  NRST_I,
    input  logic                  START_I,
    input  logic [AD_WIDTH-1:0]   BASE_I,
    input  logic [AD_WIDTH:0]     LEN_I,
    input  logic                  CONT_I,
    input  logic                  ABORT_I,
    input  logic [DATA_WIDTH-1:0] S_DATA_I,
    input  logic                  S_VALID_I,
    output logic                  S_READY_O,
    output logic                  WE_O,
    output logic [AD_WIDTH-1:0]   WADDR_O,
    output logic [DATA_WIDTH-1:0] WDATA_O,
    output logic                  BUSY_O,
    output logic                  DONE_O,
    output logic [AD_WIDTH:0]     COUNT_O,
    output logic [DATA_WIDTH-1:0] CHECKSUM_O
);

    localparam logic [AD_WIDTH:0] DEPTH_W = (AD_WIDTH + 1)'(DEPTH);
    localparam logic [AD_WIDTH:0] ONE_W   = (AD_WIDTH + 1)'(1);

    state_t                  state_q, state_d;
    logic [AD_WIDTH:0]       len_q, count_q, len_clamped;
    logic [AD_WIDTH-1:0]     base_q, addr, addr_base;
    logic                    cont_q;
    logic                    start_ok, start_acc, hs, last_hs, addr_load;
    logic                    we_q, done_q;
    logic [AD_WIDTH-1:0]     waddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    always_comb begin
        len_clamped = (LEN_I > DEPTH_W) ? DEPTH_W : LEN_I;
        start_ok    = START_I && (LEN_I != '0) && ({1'b0, BASE_I} < DEPTH_W);
        start_acc   = (state_q == IDLE) && start_ok;
        hs          = S_VALID_I && S_READY_O;
        last_hs     = hs && (count_q == len_q - ONE_W);
        // A continuous pass reloads the base on its final word so the next pass has no bubble.
        addr_load   = start_acc || (last_hs && cont_q);
        addr_base   = (state_q == IDLE) ? BASE_I : base_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK_I) begin
        if (!NRST_I) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (ABORT_I || (last_hs && !cont_q)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        S_READY_O = (state_q == RUN) && !ABORT_I;
        BUSY_O    = (state_q == RUN);
    end

    spram_wr_addr_gen #(
        .DEPTH    (DEPTH),
        .AD_WIDTH (AD_WIDTH)
    ) u_addr_gen (
        .clk   (CLK_I),
        .rst_n (NRST_I),
        .load  (addr_load),
        .base  (addr_base),
        .inc   (hs),
        .addr  (addr)
    );

    always_ff @(posedge CLK_I) begin
        if (!NRST_I) begin
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            count_q <= '0;
            len_q   <= '0;
            base_q  <= '0;
            cont_q  <= 1'b0;
        end else begin
            we_q   <= hs;
            done_q <= last_hs;
            if (hs) begin
                waddr_q <= addr;
                wdata_q <= S_DATA_I;
            end
            if (start_acc) begin
                base_q  <= BASE_I;
                len_q   <= len_clamped;
                cont_q  <= CONT_I;
                count_q <= '0;
            end else if (hs) begin
                count_q <= last_hs ? '0 : count_q + ONE_W;
            end
        end
    end

    assign WE_O    = we_q;
    assign WADDR_O = waddr_q;
    assign WDATA_O = wdata_q;
    assign DONE_O  = done_q;
    assign COUNT_O = count_q;

`ifdef SPRAM_STREAM_WRITER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;
    logic                  csum_restart_q;

    // The final XOR of a pass stays visible alongside DONE; the next pass starts fresh on its first word.
    always_ff @(posedge CLK_I) begin
        if (!NRST_I) begin
            csum_q         <= '0;
            csum_restart_q <= 1'b0;
        end else if (start_acc) begin
            csum_q         <= '0;
            csum_restart_q <= 1'b0;
        end else if (hs) begin
            csum_q         <= (csum_restart_q ? '0 : csum_q) ^ S_DATA_I;
            csum_restart_q <= last_hs && cont_q;
        end
    end

    assign CHECKSUM_O = csum_q;
`else
    assign CHECKSUM_O = '0;
`endif

endmodule

// File: tb/tb_spram_stream_writer.sv
// Directed self-checking bench for spram_stream_writer (DEPTH=256 and DEPTH=200 instances).
// Expected checksum depends on SPRAM_STREAM_WRITER_CHECKSUM_EN.
module tb_spram_stream_writer;

    logic       clk = 1'b0;
    logic       nrst;
    logic       start, cont, abort, svalid;
    logic [7:0] base, sdata;
    logic [8:0] len;
    logic       ready, we, busy, done;
    logic [7:0] waddr, wdata, csum;
    logic [8:0] count;

    logic       start2, svalid2;
    logic [7:0] base2, sdata2;
    logic [8:0] len2;
    logic       ready2, we2, busy2, done2;
    logic [7:0] waddr2, wdata2, csum2;
    logic [8:0] count2;

    int errors = 0;
    int checks = 0;
    logic [7:0] xs;
    int n;

    always #5 clk = ~clk;

    spram_stream_writer #(.DATA_WIDTH(8), .DEPTH(256)) u_dut (
        .CLK_I(clk), .NRST_I(nrst), .START_I(start), .BASE_I(base), .LEN_I(len),
        .CONT_I(cont), .ABORT_I(abort), .S_DATA_I(sdata), .S_VALID_I(svalid),
        .S_READY_O(ready), .WE_O(we), .WADDR_O(waddr), .WDATA_O(wdata),
        .BUSY_O(busy), .DONE_O(done), .COUNT_O(count), .CHECKSUM_O(csum)
    );

    spram_stream_writer #(.DATA_WIDTH(8), .DEPTH(200)) u_dut200 (
        .CLK_I(clk), .NRST_I(nrst), .START_I(start2), .BASE_I(base2), .LEN_I(len2),
        .CONT_I(1'b0), .ABORT_I(1'b0), .S_DATA_I(sdata2), .S_VALID_I(svalid2),
        .S_READY_O(ready2), .WE_O(we2), .WADDR_O(waddr2), .WDATA_O(wdata2),
        .BUSY_O(busy2), .DONE_O(done2), .COUNT_O(count2), .CHECKSUM_O(csum2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_cs(input logic [7:0] x);
`ifdef SPRAM_STREAM_WRITER_CHECKSUM_EN
        return x;
`else
        return 8'h00;
`endif
    endfunction

    initial begin
        nrst = 1'b0; start = 0; cont = 0; abort = 0; svalid = 0; base = 0; sdata = 0; len = 0;
        start2 = 0; svalid2 = 0; base2 = 0; sdata2 = 0; len2 = 0;
        tick(); tick();

        // Reset state
        check("rst_ready", ready, 0);
        check("rst_we", we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_count", count, 0);
        check("rst_csum", csum, 0);
        nrst = 1'b1;

        // Full-depth pass, BASE=0, LEN=256, data FF..00
        start = 1; base = 8'h00; len = 9'd256; cont = 0;
        tick();
        start = 0;
        check("t1_busy", busy, 1);
        check("t1_ready", ready, 1);
        check("t1_we_idle", we, 0);
        svalid = 1; sdata = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            tick();
            check("t1_we", we, 1);
            check("t1_waddr", waddr, i);
            check("t1_wdata", wdata, 8'hFF - 8'(i));
            check("t1_done", done, (i == 255));
            sdata = 8'hFF - 8'(i + 1);
        end
        check("t1_csum", csum, exp_cs(8'h00));
        check("t1_busy_after", busy, 0);
        check("t1_ready_after", ready, 0);
        check("t1_count_after", count, 0);
        svalid = 0;
        tick();
        check("t1_we_off", we, 0);
        check("t1_done_off", done, 0);
        check("t1_waddr_hold", waddr, 8'hFF);

        // Wrap across the top of memory: BASE=F0, LEN=32
        start = 1; base = 8'hF0; len = 9'd32;
        tick();
        start = 0; svalid = 1; xs = 8'h00;
        for (int i = 0; i < 32; i++) begin
            sdata = 8'(i * 7 + 3);
            xs = xs ^ sdata;
            tick();
            check("t2_waddr", waddr, 8'(8'hF0 + i));
            check("t2_done", done, (i == 31));
        end
        check("t2_csum", csum, exp_cs(xs));
        svalid = 0;

        // DEPTH=200: out-of-range base ignored, BASE=C6 wraps at 199, LEN>DEPTH clamps
        start2 = 1; base2 = 8'hC8; len2 = 9'd4;
        tick();
        check("d200_badbase", busy2, 0);
        base2 = 8'hC6;
        tick();
        start2 = 0; svalid2 = 1;
        check("d200_busy", busy2, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("d200_waddr", waddr2, (i < 2) ? 8'(8'hC6 + i) : 8'(i - 2));
            check("d200_done", done2, (i == 3));
        end
        check("d200_idle", busy2, 0);
        svalid2 = 0;
        start2 = 1; base2 = 8'h00; len2 = 9'd300;
        tick();
        start2 = 0; svalid2 = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            check("d200_clamp_waddr", waddr2, i);
            check("d200_clamp_done", done2, (i == 199));
        end
        svalid2 = 0;

        // VALID toggled 1,0,1,0,1,0,1 with LEN=4 from BASE=05
        start = 1; base = 8'h05; len = 9'd4;
        tick();
        start = 0; n = 0;
        for (int k = 0; k < 7; k++) begin
            svalid = (k % 2 == 0);
            sdata  = 8'hA0 + 8'(k);
            if (svalid) n++;
            tick();
            check("t3_we", we, svalid);
            check("t3_count", count, (n == 4) ? 0 : n);
            check("t3_done", done, svalid && (n == 4));
            if (svalid) check("t3_waddr", waddr, 8'h05 + 8'(n - 1));
        end
        svalid = 0;

        // Continuous mode: BASE=10, LEN=3, seven words
        start = 1; base = 8'h10; len = 9'd3; cont = 1;
        tick();
        start = 0; cont = 0; svalid = 1; xs = 8'h00;
        for (int i = 0; i < 7; i++) begin
            sdata = 8'h40 + 8'(i);
            xs = xs ^ sdata;
            tick();
            check("t4_waddr", waddr, 8'h10 + 8'(i % 3));
            check("t4_done", done, (i == 2) || (i == 5));
            check("t4_busy", busy, 1);
            if (i == 2 || i == 5) begin
                check("t4_csum", csum, exp_cs(xs));
                xs = 8'h00;
            end
        end
        abort = 1;
        #1;
        check("t4_abort_ready", ready, 0);
        tick();
        abort = 0; svalid = 0;
        check("t4_abort_busy", busy, 0);
        check("t4_abort_we", we, 0);
        check("t4_abort_count", count, 1);

        // ABORT after 5 of LEN=10
        start = 1; base = 8'h20; len = 9'd10;
        tick();
        start = 0; svalid = 1;
        for (int i = 0; i < 5; i++) begin
            sdata = 8'h80 + 8'(i);
            tick();
        end
        check("t5_count5", count, 5);
        abort = 1;
        #1;
        check("t5_ready_abort", ready, 0);
        tick();
        abort = 0; svalid = 0;
        check("t5_busy", busy, 0);
        check("t5_we", we, 0);
        check("t5_done", done, 0);
        check("t5_count", count, 5);
        check("t5_waddr_hold", waddr, 8'h24);

        // LEN=0 start ignored; START with ABORT high in IDLE still accepted
        start = 1; base = 8'h00; len = 9'd0;
        tick();
        check("t6_len0_busy", busy, 0);
        check("t6_len0_done", done, 0);
        len = 9'd2; abort = 1;
        tick();
        start = 0;
        check("t6_abort_idle_busy", busy, 1);
        check("t6_count_cleared", count, 0);
        tick();
        abort = 0;
        check("t6_aborted", busy, 0);

        // Reset mid-transfer
        start = 1; base = 8'h30; len = 9'd8;
        tick();
        start = 0; svalid = 1;
        for (int i = 0; i < 3; i++) begin
            sdata = 8'h5A + 8'(i);
            tick();
        end
        nrst = 0;
        tick();
        check("t7_we", we, 0);
        check("t7_waddr", waddr, 0);
        check("t7_wdata", wdata, 0);
        check("t7_count", count, 0);
        check("t7_busy", busy, 0);
        check("t7_done", done, 0);
        check("t7_ready", ready, 0);
        check("t7_csum", csum, 0);
        nrst = 1; svalid = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
